// File: rtl/vfx_stream_pkg.sv
// Shared definitions for the RGB444 Avalon-ST video stream stages.
// Frame geometry defaults, pixel layout and the region-detector state type.
package vfx_stream_pkg;

    localparam int VID_WIDTH  = 320;
    localparam int VID_HEIGHT = 240;

    localparam int PIX_W = 12;
    localparam int COL_W = 10;
    localparam int ROW_W = 9;

    localparam int RED_MSB = 11;
    localparam int RED_LSB = 8;
    localparam int GRN_MSB = 7;
    localparam int GRN_LSB = 4;
    localparam int BLU_MSB = 3;
    localparam int BLU_LSB = 0;

    localparam logic [PIX_W-1:0] EDGE_PIXEL = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        TRACK,
        DONE
    } region_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] top;
        logic [ROW_W-1:0] bottom;
        logic [COL_W-1:0] left;
        logic [COL_W-1:0] right;
    } region_t;

    // The edge filter emits all-ones or all-zeros; any set bit is an edge.
    function automatic logic pix_active(input logic [PIX_W-1:0] p);
        return p != '0;
    endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Beat-qualified column/row tracker for a raster video stream.
// A sop beat is pixel (0,0); row saturates at HEIGHT.
module pixel_position_counter
    import vfx_stream_pkg::*;
#(
    parameter int WIDTH  = VID_WIDTH,
    parameter int HEIGHT = VID_HEIGHT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sop,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             row_start,
    output logic             row_end
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(HEIGHT);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    // Position of the beat currently on the bus.
    assign col       = sop ? '0 : col_q;
    assign row       = sop ? '0 : row_q;
    assign row_start = (col == '0);
    assign row_end   = (col == COL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en) begin
            if (row_end) begin
                col_q <= '0;
                row_q <= (row == ROW_SAT) ? row : row + 1'b1;
            end else begin
                col_q <= col + 1'b1;
                row_q <= row;
            end
        end
    end

endmodule

// File: rtl/edge_region_detector.sv
// Finds the first dense band of edge pixels in each frame and reports its
// bounding box; the edge stream itself passes straight through.
module edge_region_detector
    import vfx_stream_pkg::*;
#(
    parameter int WIDTH      = VID_WIDTH,
    parameter int HEIGHT     = VID_HEIGHT,
    parameter int MARGIN     = 6,
    parameter int ROW_THRESH = 8,
    parameter int BAND_ROWS  = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready_in,
    input  logic             valid_in,
    input  logic             startofpacket_in,
    input  logic             endofpacket_in,
    input  logic [PIX_W-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic             startofpacket_out,
    output logic             endofpacket_out,
    output logic [PIX_W-1:0] data_out,
    output logic             region_valid,
    output logic [ROW_W-1:0] region_top,
    output logic [ROW_W-1:0] region_bottom,
    output logic [COL_W-1:0] region_left,
    output logic [COL_W-1:0] region_right,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    assign ready_out         = ready_in;
    assign valid_out         = valid_in;
    assign startofpacket_out = startofpacket_in;
    assign endofpacket_out   = endofpacket_in;
    assign data_out          = data_in;

    region_state_t state, st_mid, st_nx;
    region_t       band_q, band_nx, region_q;
    logic          found_q, found_nx, fin;

    logic [CNT_W-1:0] row_cnt, cnt_base, cnt_nx;
    logic [COL_W-1:0] row_min, min_base, min_nx;
    logic [COL_W-1:0] row_max, max_base, max_nx;

    logic             beat, count_en;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             row_start, row_end;
    logic             in_frame, is_edge, dense;
    logic             search_last, track_last;
    logic [ROW_W:0]   band_last;

    assign beat     = valid_in && ready_in;
    assign count_en = beat && (state != IDLE || startofpacket_in);

    pixel_position_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk       (clk),
        .reset     (reset),
        .en        (count_en),
        .sop       (startofpacket_in),
        .col       (col),
        .row       (row),
        .row_start (row_start),
        .row_end   (row_end)
    );

    assign in_frame = row < ROW_W'(HEIGHT);
    assign is_edge  = pix_active(data_in) && in_frame
                   && row >= ROW_W'(MARGIN)
                   && col >= COL_W'(MARGIN);

    // Row statistics including the beat on the bus, so row end sees its pixel.
    assign cnt_base = row_start ? '0 : row_cnt;
    assign min_base = row_start ? '1 : row_min;
    assign max_base = row_start ? '0 : row_max;

    assign cnt_nx = (is_edge && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
    assign min_nx = (is_edge && col < min_base) ? col : min_base;
    assign max_nx = (is_edge && col > max_base) ? col : max_base;
    assign dense  = cnt_nx >= CNT_W'(ROW_THRESH);

    assign band_last   = {1'b0, band_q.top} + (ROW_W + 1)'(BAND_ROWS - 1);
    assign track_last  = ({1'b0, row} == band_last)
                      || (row == ROW_W'(HEIGHT - 1));
    assign search_last = (BAND_ROWS == 1) || (row == ROW_W'(HEIGHT - 1));

    always_comb begin
        st_mid   = state;
        st_nx    = state;
        found_nx = found_q;
        band_nx  = band_q;
        fin      = 1'b0;
        if (beat) begin
            // A sop always starts over, dropping any frame in progress.
            if (startofpacket_in) begin
                st_mid   = SEARCH;
                found_nx = 1'b0;
                band_nx  = '0;
            end
            st_nx = st_mid;
            if (row_end && in_frame) begin
                unique case (st_mid)
                    SEARCH: begin
                        if (dense) begin
                            found_nx       = 1'b1;
                            band_nx.top    = row;
                            band_nx.bottom = row;
                            band_nx.left   = min_nx;
                            band_nx.right  = max_nx;
                            st_nx          = search_last ? DONE : TRACK;
                        end
                    end
                    TRACK: begin
                        if (dense) begin
                            if (min_nx < band_nx.left) band_nx.left = min_nx;
                            if (max_nx > band_nx.right) band_nx.right = max_nx;
                            band_nx.bottom = row;
                        end
                        if (track_last) st_nx = DONE;
                    end
                    default: ;
                endcase
            end
            if (endofpacket_in && st_mid != IDLE) begin
                fin   = 1'b1;
                st_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            found_q <= 1'b0;
            band_q  <= '0;
        end else begin
            state   <= st_nx;
            found_q <= found_nx;
            band_q  <= band_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt <= '0;
            row_min <= '1;
            row_max <= '0;
        end else if (count_en) begin
            row_cnt <= cnt_nx;
            row_min <= min_nx;
            row_max <= max_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region_valid <= 1'b0;
            region_q     <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= fin;
            if (fin) begin
                region_valid <= found_nx;
                region_q     <= found_nx ? band_nx : '0;
            end
        end
    end

    assign region_top    = region_q.top;
    assign region_bottom = region_q.bottom;
    assign region_left   = region_q.left;
    assign region_right  = region_q.right;

endmodule

// File: tb/tb_edge_region_detector.sv
// Directed bench for edge_region_detector on a reduced 32x24 frame.
// Expected band boxes are worked out by hand from the pixel patterns.
module tb_edge_region_detector;

    localparam int W = 32;
    localparam int H = 24;
    localparam int M = 2;
    localparam int T = 4;
    localparam int B = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic [11:0] data_in = '0;
    logic        ready_out, valid_out, sop_out, eop_out;
    logic [11:0] data_out;
    logic        region_valid, frame_done;
    logic [8:0]  region_top, region_bottom;
    logic [9:0]  region_left, region_right;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int cyc = 0;
    int n0;

    always #5 clk = ~clk;

    edge_region_detector #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .MARGIN     (M),
        .ROW_THRESH (T),
        .BAND_ROWS  (B)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ready_in          (ready_in),
        .valid_in          (valid_in),
        .startofpacket_in  (sop_in),
        .endofpacket_in    (eop_in),
        .data_in           (data_in),
        .ready_out         (ready_out),
        .valid_out         (valid_out),
        .startofpacket_out (sop_out),
        .endofpacket_out   (eop_out),
        .data_out          (data_out),
        .region_valid      (region_valid),
        .region_top        (region_top),
        .region_bottom     (region_bottom),
        .region_left       (region_left),
        .region_right      (region_right),
        .frame_done        (frame_done)
    );

    always @(negedge clk) if (frame_done) fd_count++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit pix(input int pat, input int r, input int c);
        case (pat)
            1: return r >= 5 && r <= 9 && c >= 10 && c <= 20;
            2: return r == 0 || c < 2
                   || (r == 4 && c >= 10 && c <= 12)
                   || (r == 5 && c >= 14 && c <= 17);
            3: return (r >= 3 && r <= 8 && c >= 10 && c <= 15)
                   || (r >= 9 && r <= 20 && c >= 4 && c <= 30);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_beat(input logic [11:0] d, input bit s, input bit e,
                              input bit gaps, input bit chk);
        bit done = 1'b0;
        int tries = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            tries++;
            if (gaps) begin
                valid_in = cyc[0];
                ready_in = (cyc % 300) >= 100;
            end else begin
                valid_in = 1'b1;
                ready_in = 1'b1;
            end
            if (valid_in && ready_in) begin
                data_in = d;
                sop_in  = s;
                eop_in  = e;
                done    = 1'b1;
            end else begin
                data_in = 12'hFFF;
                sop_in  = 1'b1;
                eop_in  = 1'b1;
            end
            if (chk) begin
                #1;
                check("passthru",
                      {ready_out, valid_out, sop_out, eop_out, data_out},
                      {ready_in, valid_in, sop_in, eop_in, data_in});
            end
            if (tries > 1000) begin
                check("beat_timeout", 0, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int pat, input bit gaps, input int last_row,
                              input bit do_sop, input bit do_eop, input bit chk);
        for (int r = 0; r <= last_row; r++)
            for (int c = 0; c < W; c++)
                drive_beat(pix(pat, r, c) ? 12'hFFF : 12'h000,
                           do_sop && r == 0 && c == 0,
                           do_eop && r == last_row && c == W - 1,
                           gaps, chk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        data_in  = '0;
    endtask

    task automatic expect_result(input string tag, input bit v, input int t,
                                 input int b, input int l, input int r);
        go_idle();
        #1;
        check({tag, "_fd"}, frame_done, 1);
        check({tag, "_valid"}, region_valid, v);
        check({tag, "_top"}, region_top, t);
        check({tag, "_bottom"}, region_bottom, b);
        check({tag, "_left"}, region_left, l);
        check({tag, "_right"}, region_right, r);
        @(negedge clk);
        #1;
        check({tag, "_fd_off"}, frame_done, 0);
        check({tag, "_hold"}, {region_valid, region_top, region_left},
              {v, 9'(t), 10'(l)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_fd", frame_done, 0);
        check("rst_valid", region_valid, 0);
        check("rst_box", {region_top, region_bottom, region_left, region_right}, 0);
        reset = 1'b0;

        send_frame(1, 0, H - 1, 1, 1, 1);
        expect_result("dense", 1, 5, 9, 10, 20);

        send_frame(0, 0, H - 1, 1, 1, 1);
        expect_result("zero", 0, 0, 0, 0, 0);

        send_frame(2, 0, H - 1, 1, 1, 0);
        expect_result("thresh", 1, 5, 5, 14, 17);

        send_frame(3, 0, H - 1, 1, 1, 0);
        expect_result("band", 1, 3, 8, 10, 15);

        n0 = fd_count;
        send_frame(1, 0, 12, 1, 0, 0);
        send_frame(2, 0, H - 1, 1, 1, 0);
        expect_result("abort", 1, 5, 5, 14, 17);
        repeat (3) @(negedge clk);
        check("abort_count", fd_count, n0 + 1);

        send_frame(1, 0, 7, 1, 0, 0);
        go_idle();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", region_valid, 0);
        check("rst_mid_box", {region_top, region_bottom, region_left, region_right}, 0);
        @(negedge clk);
        reset = 1'b0;
        n0 = fd_count;
        send_frame(1, 0, H - 1, 0, 1, 0);
        go_idle();
        repeat (3) @(negedge clk);
        check("nosop_count", fd_count, n0);
        check("nosop_valid", region_valid, 0);

        drive_beat(12'hFFF, 1, 1, 0, 0);
        expect_result("single", 0, 0, 0, 0, 0);

        send_frame(1, 0, 7, 1, 1, 0);
        expect_result("early_eop", 1, 5, 7, 10, 20);

        cyc = 0;
        send_frame(1, 1, H - 1, 1, 1, 0);
        expect_result("gaps", 1, 5, 9, 10, 20);

        repeat (2) @(negedge clk);
        check("total_fd", fd_count, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_region_detector.md
# edge_region_detector

- Sits directly downstream of the edge filter on the 320x240 RGB444 Avalon-ST video stream.
- Passes the binary edge map through unchanged.
- Locates the first horizontal band of the frame that has a dense run of edge pixels, usually the top of a head. It reports that band's bounding box once per frame.
- Its registered region outputs drive the face-blur stage: blur start/end columns and top/bottom rows.

## Interface
Parameters:
- WIDTH, 320: pixels per row.
- HEIGHT, 240: rows per frame.
- MARGIN, 6: rows/cols below this index are ignored (edge-filter warm-up garbage).
- ROW_THRESH, 8: minimum edge pixels in a row for it to count as "dense".
- BAND_ROWS, 60: rows tracked after the first dense row.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- ready_in  in  1  downstream ready.
- valid_in  in  1  upstream beat valid.
- startofpacket_in  in  1  first pixel of frame.
- endofpacket_in  in  1  last pixel of frame.
- data_in  in  12  edge map pixel (12'hFFF edge, 12'h000 none).
- ready_out  out  1  = ready_in (combinational).
- valid_out, startofpacket_out, endofpacket_out  out  1 each  = corresponding inputs (combinational).
- data_out  out  12  = data_in (combinational).
- region_valid  out  1  last completed frame contained a dense band.
- region_top, region_bottom  out  9  band rows.
- region_left, region_right  out  10  band columns.
- frame_done  out  1  one-cycle pulse when region_* update.

## Operation
- Beat = valid_in && ready_in. Non-beat cycles change no state.
- Edge pixel: data_in != 0, row >= MARGIN, col >= MARGIN, row < HEIGHT.
- Position counters: a beat with startofpacket_in is pixel (0,0). Col increments per beat and wraps at WIDTH-1 to 0, incrementing row. Row saturates at HEIGHT; beats at row >= HEIGHT are ignored.
- Per-row registers: row_cnt (edge count), row_min/row_max (edge column extents). All three clear at each row start.
- "Row end" is the beat with col == WIDTH-1. Its evaluation includes that beat's pixel.
- FSM states:
  - IDLE: waiting for startofpacket_in. A sop beat enters SEARCH.
  - SEARCH: at row end, if row_cnt >= ROW_THRESH, go to TRACK. Capture top = row, band_left = row_min, band_right = row_max, bottom = row.
  - TRACK: at each dense row end, band_left = min, band_right = max, bottom = row. When row == top+BAND_ROWS-1 (or row == HEIGHT-1), go to DONE.
  - DONE: ignores pixels.
- From SEARCH, TRACK or DONE, an endofpacket_in beat goes to IDLE and finalizes.
- Finalize:
  - region_valid = (a dense row was found).
  - If found: region_* = captured values. If not: all region_* = 0.
  - Pulse frame_done.
- Sop beat in any non-IDLE state (truncated frame): abort, no finalize/no frame_done. Restart SEARCH with that beat as (0,0).
- Sop and eop on the same beat: start then finalize immediately. Result region_valid = 0 unless single-pixel WIDTH rules make a dense row (they cannot with defaults).
- Eop before row HEIGHT-1: finalize normally using data so far.
- Beats while IDLE without sop are ignored (no counting).

## Timing
- Stream path has zero latency and is fully combinational. The block never backpressures beyond ready_in.
- region_* and frame_done are registered. They update on the clock edge that accepts the eop beat, so they are visible the following cycle.
- frame_done is high exactly one cycle.
- region_* hold their values until the next finalize.
- Reset values: all region_* = 0, region_valid = 0, frame_done = 0, FSM = IDLE, counters 0.
- Reset asserted mid-frame: everything returns to reset values asynchronously. The next frame starts only on a sop beat.
- Widths:
  - row_cnt is $clog2(WIDTH+1) bits and saturates.
  - Columns are zero-extended to 10 bits, rows to 9 bits.

## Structure
- Package vfx_stream_pkg holds:
  - WIDTH/HEIGHT defaults.
  - RGB444 field positions.
  - EDGE_PIXEL = 12'hFFF.
  - The enum region_state_t {IDLE, SEARCH, TRACK, DONE}.
- Sub-module pixel_position_counter handles beat-qualified col/row counting. It has sop restart, row wrap and saturation, and outputs row_start / row_end strobes. It is reused by other stream stages.

## Test plan
- Frame with edges only in rows 50–70, cols 100–180, each row 81 edges → frame_done one cycle after eop. region_valid=1, top=50, bottom=70, left=100, right=180.
- All-zero frame → region_valid=0, all coords 0, frame_done pulses. Passthrough data_out matches data_in every cycle.
- Row 40 with 7 edges and row 41 with 8 edges → top=41. Edges at rows 0–5 / cols 0–5 are never counted.
- Dense rows 20–200 → bottom=79 (20+BAND_ROWS-1). Edges after row 79 do not widen left/right.
- valid_in toggling every other cycle and ready_in low for 100-cycle bursts → results identical to the uninterrupted run.
- Mid-frame sop at row 120 → no frame_done for the aborted frame; next eop reports the new frame only.
- reset pulse during TRACK → region outputs 0 immediately.
